// File: rtl/word_pkg.sv
// Shared encodings for the message overlay: game states, ROM message codes,
// overlay FSM states and the game-state to message mapping.
package word_pkg;

  typedef enum logic [1:0] {
    GS_WAIT = 2'b00,
    GS_PLAY = 2'b01,
    GS_LOST = 2'b10,
    GS_WON  = 2'b11
  } game_state_e;

  typedef enum logic [1:0] {
    MSG_WAIT = 2'b00,
    MSG_LOSE = 2'b01,
    MSG_NONE = 2'b10,
    MSG_WIN  = 2'b11
  } msg_e;

  typedef enum logic [1:0] {
    ST_HIDDEN    = 2'b00,
    ST_SHOW      = 2'b01,
    ST_BLINK_OFF = 2'b10
  } scan_state_e;

  function automatic msg_e msg_of(game_state_e gs);
    case (gs)
      GS_WAIT: msg_of = MSG_WAIT;
      GS_LOST: msg_of = MSG_LOSE;
      GS_WON:  msg_of = MSG_WIN;
      default: msg_of = MSG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/word_box_map.sv
// Maps the current pixel onto a 16x16 glyph cell of the message box and
// registers the cell address plus the in-box flag one cycle after the pixel.
module word_box_map #(
  parameter int ORIGIN_X   = 256,
  parameter int ORIGIN_Y   = 176,
  parameter int SCALE_LOG2 = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  output logic [3:0] rom_row,
  output logic [3:0] rom_col,
  output logic       in_box
);

  localparam int SPAN = 16 << SCALE_LOG2;

  logic [9:0] dx, dy;
  logic       in_box_d;
  logic [3:0] row_d, col_d;
  logic [3:0] row_q, col_q;
  logic       in_box_q;

  // Wrapping 10-bit offsets: a pixel left of / above the origin wraps to a
  // large value, so a single unsigned compare covers both box edges.
  assign dx       = pixel_x - 10'(ORIGIN_X);
  assign dy       = pixel_y - 10'(ORIGIN_Y);
  assign in_box_d = ({1'b0, dx} < 11'(SPAN)) && ({1'b0, dy} < 11'(SPAN));
  assign col_d    = in_box_d ? dx[SCALE_LOG2 +: 4] : 4'd0;
  assign row_d    = in_box_d ? dy[SCALE_LOG2 +: 4] : 4'd0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_q    <= '0;
      col_q    <= '0;
      in_box_q <= 1'b0;
    end else begin
      row_q    <= row_d;
      col_q    <= col_d;
      in_box_q <= in_box_d;
    end
  end

  assign rom_row = row_q;
  assign rom_col = col_q;
  assign in_box  = in_box_q;

endmodule

// File: rtl/word_scan_ctrl.sv
// Message overlay controller: latches game state on frame_tick, blinks the
// waiting message, and gates glyph ROM pixels through a 3-cycle pipeline.
module word_scan_ctrl
  import word_pkg::*;
#(
  parameter int ORIGIN_X     = 256,
  parameter int ORIGIN_Y     = 176,
  parameter int SCALE_LOG2   = 3,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] game_state,
  input  logic       frame_tick,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       rom_bit,
  output logic [3:0] rom_row,
  output logic [3:0] rom_col,
  output logic [1:0] rom_select,
  output logic       text_on
);

  localparam int             CW       = $clog2(BLINK_FRAMES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(BLINK_FRAMES - 1);

  scan_state_e   state_q, state_d;
  game_state_e   gs_q, gs_d, gs_in;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;  // 1 = visible half of the blink
  logic          ib_d1, ib_d2_q;
  logic [2:1]    vis_q;
  logic          text_on_q;

  word_box_map #(
    .ORIGIN_X  (ORIGIN_X),
    .ORIGIN_Y  (ORIGIN_Y),
    .SCALE_LOG2(SCALE_LOG2)
  ) u_map (
    .clock  (clock),
    .reset  (reset),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .rom_row(rom_row),
    .rom_col(rom_col),
    .in_box (ib_d1)
  );

  assign gs_in = game_state_e'(game_state);

  always_comb begin
    state_d = state_q;
    gs_d    = gs_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (frame_tick) begin
      gs_d = gs_in;
      if (gs_in != gs_q) begin
        cnt_d   = '0;
        phase_d = 1'b1;
      end else if (gs_in == GS_WAIT) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      case (gs_in)
        GS_PLAY:         state_d = ST_HIDDEN;
        GS_LOST, GS_WON: state_d = ST_SHOW;
        default:         state_d = phase_d ? ST_SHOW : ST_BLINK_OFF;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_HIDDEN;
      gs_q    <= GS_PLAY;
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      state_q <= state_d;
      gs_q    <= gs_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Visibility is captured with the pixel so in-flight pixels keep the
  // visibility that applied when they were presented.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vis_q     <= '0;
      ib_d2_q   <= 1'b0;
      text_on_q <= 1'b0;
    end else begin
      vis_q[1]  <= (state_q == ST_SHOW);
      vis_q[2]  <= vis_q[1];
      ib_d2_q   <= ib_d1;
      text_on_q <= rom_bit & ib_d2_q & vis_q[2];
    end
  end

  assign rom_select = msg_of(gs_q);
  assign text_on    = text_on_q;

endmodule

// File: tb/tb_word_scan_ctrl.sv
// Randomized scoreboard bench for word_scan_ctrl against a frame-level model.
module tb_word_scan_ctrl;

  localparam int OX = 256, OY = 176, S = 3, BF = 30;
  localparam int SPAN = 16 << S;

  logic       clock, reset, frame_tick, rom_bit, text_on;
  logic [1:0] game_state, rom_select;
  logic [9:0] pixel_x, pixel_y;
  logic [3:0] rom_row, rom_col;

  word_scan_ctrl #(
    .ORIGIN_X(OX), .ORIGIN_Y(OY), .SCALE_LOG2(S), .BLINK_FRAMES(BF)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .game_state(game_state),
    .frame_tick(frame_tick),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .rom_bit   (rom_bit),
    .rom_row   (rom_row),
    .rom_col   (rom_col),
    .rom_select(rom_select),
    .text_on   (text_on)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [3:0] rc, rr;
    logic [1:0] sel;
    logic       ton;
  } exp_t;

  exp_t q[$];
  int total = 0, bad = 0;

  // Frame-level model: latched game state and ticks since it last changed.
  logic [1:0] m_gs;
  int         m_k;
  bit         h_ib[2], h_vis[2];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic bit m_shown();
    case (m_gs)
      2'b10, 2'b11: return 1'b1;
      2'b00:        return ((m_k / BF) % 2) == 0;
      default:      return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] m_sel(input logic [1:0] gs);
    case (gs)
      2'b00:   return 2'b00;
      2'b10:   return 2'b01;
      2'b11:   return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic m_reset();
    m_gs = 2'b01;
    m_k  = 0;
    h_ib[0] = 0; h_ib[1] = 0; h_vis[0] = 0; h_vis[1] = 0;
  endtask

  // Drive one pixel cycle and queue the response due on the next cycle.
  task automatic step(input int x, input int y, input logic [1:0] gs,
                      input logic tk, input logic rb);
    exp_t e;
    bit   ib, vis;
    pixel_x = 10'(x); pixel_y = 10'(y);
    game_state = gs; frame_tick = tk; rom_bit = rb;
    ib  = (x >= OX) && (x < OX + SPAN) && (y >= OY) && (y < OY + SPAN);
    vis = m_shown();
    e.due = cyc + 1;
    e.rc  = ib ? 4'((x - OX) >> S) : 4'd0;
    e.rr  = ib ? 4'((y - OY) >> S) : 4'd0;
    e.ton = rb & h_ib[1] & h_vis[1];
    if (tk) begin
      if (gs != m_gs) begin m_gs = gs; m_k = 0; end
      else m_k++;
    end
    e.sel = m_sel(m_gs);
    q.push_back(e);
    h_ib[1] = h_ib[0]; h_vis[1] = h_vis[0];
    h_ib[0] = ib;      h_vis[0] = vis;
    @(posedge clock); #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_text_on"}, int'(text_on), 0);
    chk({tag, "_rom_select"}, int'(rom_select), 2);
    chk({tag, "_rom_row"}, int'(rom_row), 0);
    chk({tag, "_rom_col"}, int'(rom_col), 0);
  endtask

  // Asynchronous reset pulse landing between clock edges.
  task automatic mid_reset();
    #2;
    reset = 1'b1;
    q.delete();
    #1;
    chk_reset_outs("async_rst");
    @(posedge clock); @(posedge clock); #1;
    chk_reset_outs("held_rst");
    reset = 1'b0;
    m_reset();
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
        exp_t e;
        e = q.pop_front();
        if (e.due < cyc) chk("missed_slot", e.due, cyc);
        else begin
          chk("rom_col", int'(rom_col), int'(e.rc));
          chk("rom_row", int'(rom_row), int'(e.rr));
          chk("rom_select", int'(rom_select), int'(e.sel));
          chk("text_on", int'(text_on), int'(e.ton));
        end
      end
    end
  end

  initial begin
    reset = 1'b1; frame_tick = 0; rom_bit = 0; game_state = 2'b00;
    pixel_x = 0; pixel_y = 0;
    m_reset();
    repeat (3) @(posedge clock);
    #1;
    chk_reset_outs("reset");
    reset = 1'b0;

    // Lost message at the box origin, then corners and just outside.
    step(0, 0, 2'b10, 1, 0);
    repeat (4) step(256, 176, 2'b10, 0, 1);
    step(383, 303, 2'b10, 0, 1);
    step(384, 303, 2'b10, 0, 1);
    step(383, 304, 2'b10, 0, 1);
    step(255, 200, 2'b10, 0, 1);
    repeat (3) step(300, 200, 2'b10, 0, 1);

    // Reset while the overlay is lit; nothing shows until the next tick.
    repeat (3) step(300, 200, 2'b10, 0, 1);
    mid_reset();
    repeat (6) step(300, 200, 2'b10, 0, 1);
    step(300, 200, 2'b10, 1, 1);
    repeat (4) step(300, 200, 2'b10, 0, 1);

    // Lost -> won between ticks: message changes only at the tick.
    repeat (5) step(310, 210, 2'b11, 0, 1);
    step(310, 210, 2'b11, 1, 1);
    repeat (4) step(310, 210, 2'b11, 0, 1);

    // Playing hides the overlay despite rom_bit high.
    step(310, 210, 2'b01, 1, 1);
    repeat (8) step(320 + $urandom_range(0, 60), 200, 2'b01, 0, 1);

    // Waiting message blink over 61 ticks.
    for (int t = 1; t <= 61; t++) begin
      step(330, 220, 2'b00, 1, 1);
      step(331, 221, 2'b00, 0, 1);
      step(332, 222, 2'b00, 0, 1);
    end
    repeat (3) step(330, 220, 2'b00, 0, 1);

    // Randomized traffic.
    begin
      logic [1:0] gs;
      gs = 2'b00;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 299) == 0) gs = 2'($urandom_range(0, 3));
        step($urandom_range(240, 400), $urandom_range(160, 320), gs,
             ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
      end
    end

    @(negedge clock); #1;
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/word_scan_ctrl.md
WORD_SCAN_CTRL -- requirements
Module: word_scan_ctrl

Interface
REQ-001 Parameter ORIGIN_X, default 256: left pixel column of the message box.
REQ-002 Parameter ORIGIN_Y, default 176: top pixel row of the message box.
REQ-003 Parameter SCALE_LOG2, default 3: each glyph cell is 2^SCALE_LOG2 x 2^SCALE_LOG2 pixels; the box is 16 cells square.
REQ-004 Parameter BLINK_FRAMES, default 30: frames per blink phase for the waiting message.
REQ-005 Ports: clock and reset come first; one clock; reset is asynchronous and active-high.
REQ-006 clock  in  1  pixel clock.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 game_state  in  2  00 waiting, 01 playing, 10 lost, 11 won.
REQ-009 frame_tick  in  1  one-cycle pulse at start of vertical blank.
REQ-010 pixel_x  in  10  current pixel column.
REQ-011 pixel_y  in  10  current pixel row.
REQ-012 rom_bit  in  1  glyph ROM pixel, valid one cycle after rom_row/rom_col/rom_select.
REQ-013 rom_row  out  4  glyph row to ROM.
REQ-014 rom_col  out  4  glyph column to ROM.
REQ-015 rom_select  out  2  message code to ROM: 00 wait, 01 lose, 10 none, 11 win.
REQ-016 text_on  out  1  overlay pixel enable.

Function
REQ-017 game_state SHALL be sampled only on frame_tick; changes between ticks SHALL have no effect until the next tick.
REQ-018 FSM states HIDDEN, SHOW, BLINK_OFF; on frame_tick: playing -> HIDDEN; lost or won -> SHOW; waiting -> SHOW or BLINK_OFF per blink phase.
REQ-019 Latched message SHALL map waiting->00, lost->01, won->11, playing->10 onto rom_select.
REQ-020 Frame counter SHALL increment on each frame_tick in waiting; at BLINK_FRAMES-1 it wraps to 0 and the blink phase toggles.
REQ-021 Frame counter and blink phase (visible) SHALL clear on any frame_tick where the sampled game_state differs from the latched one.
REQ-022 in_box = pixel_x in [ORIGIN_X, ORIGIN_X+16*2^SCALE_LOG2) and pixel_y in [ORIGIN_Y, ORIGIN_Y+16*2^SCALE_LOG2); bounds inclusive-low, exclusive-high.
REQ-023 When in_box, rom_col = (pixel_x-ORIGIN_X)>>SCALE_LOG2 and rom_row = (pixel_y-ORIGIN_Y)>>SCALE_LOG2, registered one cycle after the pixel; subtraction 10-bit unsigned, only the low 4 bits of the shifted result used.
REQ-024 When not in_box, rom_row and rom_col SHALL be 0.
REQ-025 in_box and state-visible flags SHALL be delayed in step with the ROM so text_on (registered) = rom_bit AND in_box_d2 AND visible_d2, valid 3 cycles after the pixel.
REQ-026 text_on SHALL be 0 whenever state is HIDDEN or BLINK_OFF, irrespective of rom_bit.
REQ-027 A state change on frame_tick SHALL take effect for pixels presented from the cycle after the tick; pixels already in the pipeline complete with the old visibility.

Reset
REQ-028 While reset is high: state HIDDEN, rom_select 10, rom_row 0, rom_col 0, text_on 0, frame counter 0, blink phase visible, all pipeline flags 0.
REQ-029 Reset asserted mid-frame SHALL force text_on low immediately (asynchronous); after release the FSM waits for the next frame_tick before showing anything.

Structure
REQ-030 Shared package word_pkg SHALL hold the game_state encodings, the rom_select message codes and the FSM state type.
REQ-031 Coordinate-to-cell mapping (REQ-022..024) SHALL be a sub-module word_box_map; FSM, blink counter and pipeline stay in word_scan_ctrl.

Verification
REQ-032 Reset, then game_state=10 and a frame_tick -> rom_select=01, state SHOW; pixel (256,176) with rom_bit=1 -> text_on=1 three cycles later.
REQ-033 State SHOW, pixel (383,303) -> rom_col=15, rom_row=15; pixel (384,303) -> rom_row=rom_col=0 and text_on=0 three cycles later despite rom_bit=1.
REQ-034 game_state=00 held for 61 frame_ticks -> visible ticks 1-30, hidden ticks 31-60, visible from tick 61.
REQ-035 game_state changes 10->11 mid-frame -> rom_select stays 01 until the next frame_tick, then 11, and the frame counter clears.
REQ-036 game_state=01 -> rom_select=10, text_on=0 for the whole frame with rom_bit forced 1.
REQ-037 Reset pulsed while text_on=1 -> text_on=0 in the same cycle; no overlay until the first frame_tick after release.
